process_element_div_22s_15ns_7s_seq: RTL and testbench

//  Sequential signed/unsigned divider. Inverse of the PE's 7s x 15ns -> 22s multiply path:

---
 rtl/process_element_div_22s_15ns_7s_seq.sv | 150 +++++++++++++++
 tb/tb_process_element_div_22s_15ns_7s_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/process_element_div_22s_15ns_7s_seq.sv
// Sequential restoring divider for the PE requantization path: signed dividend by an
// unsigned scale, giving a saturated signed quotient and a dividend-signed remainder.
module process_element_div_22s_15ns_7s_seq #(
    parameter int DIVIDEND_WIDTH = 22,
    parameter int DIVISOR_WIDTH  = 15,
    parameter int QUOTIENT_WIDTH = 7
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ce,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DIVIDEND_WIDTH-1:0]  dividend,
    input  logic [DIVISOR_WIDTH-1:0]   divisor,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [QUOTIENT_WIDTH-1:0]  quotient,
    output logic [DIVISOR_WIDTH:0]     remainder,
    output logic                       sat,
    output logic                       div_zero
);

    localparam int RW = DIVISOR_WIDTH + 1;
    localparam int CW = $clog2(DIVIDEND_WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(DIVIDEND_WIDTH - 1);
    localparam logic [DIVIDEND_WIDTH-1:0] POS_LIMIT = DIVIDEND_WIDTH'(2**(QUOTIENT_WIDTH-1) - 1);
    localparam logic [DIVIDEND_WIDTH-1:0] NEG_LIMIT = DIVIDEND_WIDTH'(2**(QUOTIENT_WIDTH-1));
    localparam logic [QUOTIENT_WIDTH-1:0] Q_MAX = {1'b0, {(QUOTIENT_WIDTH-1){1'b1}}};
    localparam logic [QUOTIENT_WIDTH-1:0] Q_MIN = {1'b1, {(QUOTIENT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                      state_q;
    logic [DIVIDEND_WIDTH-1:0]   dvdMag_q;
    logic [DIVIDEND_WIDTH-1:0]   quoMag_q;
    logic [RW-1:0]               remPart_q;
    logic [DIVISOR_WIDTH-1:0]    divisor_q;
    logic                        neg_q;
    logic                        divZero_q;
    logic [CW-1:0]               iter_q;
    logic                        outValid_q;
    logic [QUOTIENT_WIDTH-1:0]   quotient_q;
    logic [RW-1:0]               remainder_q;
    logic                        sat_q;
    logic                        divZeroOut_q;

    logic [DIVIDEND_WIDTH-1:0]   dvdAbs;
    logic [RW-1:0]               remShift;
    logic [RW-1:0]               remSub;
    logic                        qBit;
    logic [RW-1:0]               remPart_d;
    logic [QUOTIENT_WIDTH-1:0]   quotient_d;
    logic [RW-1:0]               remainder_d;
    logic                        sat_d;

    assign in_ready  = ce & (state_q == IDLE);
    assign out_valid = outValid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign sat       = sat_q;
    assign div_zero  = divZeroOut_q;

    // Two's-complement negation of -2^(N-1) yields 2^(N-1), which is correct read as unsigned.
    assign dvdAbs = dividend[DIVIDEND_WIDTH-1] ? -dividend : dividend;

    always_comb begin
        remShift  = {remPart_q[RW-2:0], dvdMag_q[DIVIDEND_WIDTH-1]};
        remSub    = remShift - {1'b0, divisor_q};
        qBit      = (remShift >= {1'b0, divisor_q});
        remPart_d = qBit ? remSub : remShift;
    end

    always_comb begin
        quotient_d  = neg_q ? -quoMag_q[QUOTIENT_WIDTH-1:0] : quoMag_q[QUOTIENT_WIDTH-1:0];
        remainder_d = neg_q ? -remPart_q : remPart_q;
        sat_d       = 1'b0;
        if (divZero_q) begin
            quotient_d  = neg_q ? Q_MIN : Q_MAX;
            remainder_d = '0;
            sat_d       = 1'b1;
        end else if (!neg_q && (quoMag_q > POS_LIMIT)) begin
            quotient_d = Q_MAX;
            sat_d      = 1'b1;
        end else if (neg_q && (quoMag_q > NEG_LIMIT)) begin
            quotient_d = Q_MIN;
            sat_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            dvdMag_q     <= '0;
            quoMag_q     <= '0;
            remPart_q    <= '0;
            divisor_q    <= '0;
            neg_q        <= 1'b0;
            divZero_q    <= 1'b0;
            iter_q       <= '0;
            outValid_q   <= 1'b0;
            quotient_q   <= '0;
            remainder_q  <= '0;
            sat_q        <= 1'b0;
            divZeroOut_q <= 1'b0;
        end else if (ce) begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        dvdMag_q  <= dvdAbs;
                        divisor_q <= divisor;
                        neg_q     <= dividend[DIVIDEND_WIDTH-1];
                        divZero_q <= (divisor == '0);
                        quoMag_q  <= '0;
                        remPart_q <= '0;
                        iter_q    <= '0;
                        state_q   <= (divisor == '0) ? DONE : CALC;
                    end
                end
                CALC: begin
                    remPart_q <= remPart_d;
                    quoMag_q  <= {quoMag_q[DIVIDEND_WIDTH-2:0], qBit};
                    dvdMag_q  <= {dvdMag_q[DIVIDEND_WIDTH-2:0], 1'b0};
                    iter_q    <= iter_q + CW'(1);
                    if (iter_q == LAST_ITER) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // First DONE edge formats the result; later edges wait for the consumer.
                    if (!outValid_q) begin
                        outValid_q   <= 1'b1;
                        quotient_q   <= quotient_d;
                        remainder_q  <= remainder_d;
                        sat_q        <= sat_d;
                        divZeroOut_q <= divZero_q;
                    end else if (out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_process_element_div_22s_15ns_7s_seq.sv
// Self-checking bench for the sequential divider: directed corner cases plus random
// operations compared against an integer-arithmetic reference model.
module tb_process_element_div_22s_15ns_7s_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic        in_ready;
    logic [21:0] dividend;
    logic [14:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  quotient;
    logic [15:0] remainder;
    logic        sat;
    logic        div_zero;

    int errors = 0;
    int checks = 0;

    process_element_div_22s_15ns_7s_seq dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .sat       (sat),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: SV integer division truncates toward zero and % follows the dividend sign.
    function automatic void model(input int a, input int b, output int q, output int r,
                                  output int s, output int z);
        int full;
        if (b == 0) begin
            z = 1; s = 1; r = 0;
            q = (a < 0) ? -64 : 63;
        end else begin
            z = 0;
            full = a / b;
            r = a % b;
            if (full > 63) begin
                q = 63; s = 1;
            end else if (full < -64) begin
                q = -64; s = 1;
            end else begin
                q = full; s = 0;
            end
        end
    endfunction

    task automatic applyStimulus(input int a, input int b, input int stallAt,
                                 input int stallLen, input int holdLen);
        int q, r, s, z, n, expLat;
        model(a, b, q, r, s, z);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 32'(in_ready), 1);
            return;
        end
        dividend = a[21:0];
        divisor  = b[14:0];
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 80) begin
            if (n == stallAt) ce = 1'b0;
            if (n == stallAt + stallLen) ce = 1'b1;
            if (n == 2) checkOutput("in_ready_busy", 32'(in_ready), 0);
            @(negedge clk);
            n++;
        end
        ce = 1'b1;
        expLat = (b == 0) ? 1 : 23 + stallLen;
        checkOutput($sformatf("latency %0d/%0d", a, b), n, expLat);
        checkOutput($sformatf("quotient %0d/%0d", a, b), $signed(quotient), q);
        checkOutput($sformatf("remainder %0d/%0d", a, b), $signed(remainder), r);
        checkOutput($sformatf("sat %0d/%0d", a, b), 32'(sat), s);
        checkOutput($sformatf("div_zero %0d/%0d", a, b), 32'(div_zero), z);
        checkOutput("in_ready_done", 32'(in_ready), 0);
        for (int i = 0; i < holdLen; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", 32'(out_valid), 1);
            checkOutput("hold_quotient", $signed(quotient), q);
            checkOutput("hold_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("drain_valid", 32'(out_valid), 0);
        checkOutput("drain_in_ready", 32'(in_ready), 1);
    endtask

    initial begin
        int a, b, mode, seen;
        logic [21:0] raw;
        reset     = 1'b1;
        ce        = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_out_valid", 32'(out_valid), 0);
        checkOutput("reset_quotient", 32'(quotient), 0);
        checkOutput("reset_remainder", 32'(remainder), 0);
        checkOutput("reset_flags", {30'd0, sat, div_zero}, 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_in_ready", 32'(in_ready), 1);
        ce = 1'b0;
        #1;
        checkOutput("ce_low_in_ready", 32'(in_ready), 0);
        ce = 1'b1;

        applyStimulus(300, 7, -1, 0, 0);
        applyStimulus(-300, 7, -1, 0, 0);
        applyStimulus(-1000, 20, -1, 0, 0);
        applyStimulus(5000, 10, -1, 0, 0);
        applyStimulus(-2097152, 1, -1, 0, 0);
        applyStimulus(2097151, 32767, -1, 0, 0);
        applyStimulus(630, 10, -1, 0, 0);
        applyStimulus(640, 10, -1, 0, 0);
        applyStimulus(-640, 10, -1, 0, 0);
        applyStimulus(-650, 10, -1, 0, 0);
        applyStimulus(123, 0, -1, 0, 0);
        applyStimulus(-5, 0, -1, 0, 0);
        applyStimulus(0, 0, -1, 0, 0);
        applyStimulus(300, 7, -1, 0, 5);
        applyStimulus(300, 7, 5, 4, 0);

        // Abort an operation mid-division and confirm nothing emerges afterwards.
        dividend = 22'd300;
        divisor  = 15'd7;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_in_ready", 32'(in_ready), 1);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        checkOutput("abort_no_valid", seen, 0);
        applyStimulus(300, 7, -1, 0, 0);

        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 3);
            case (mode)
                0: begin
                    b = $urandom_range(1, 127);
                    a = int'($urandom_range(0, b * 140)) - b * 70;
                end
                1: begin
                    raw = 22'($urandom);
                    a = {{10{raw[21]}}, raw};
                    b = int'($urandom_range(0, 32767));
                end
                2: begin
                    raw = 22'($urandom);
                    a = {{10{raw[21]}}, raw};
                    b = 0;
                end
                default: begin
                    a = int'($urandom_range(0, 16000)) - 8000;
                    b = $urandom_range(1, 200);
                end
            endcase
            applyStimulus(a, b, (i % 5 == 0) ? int'($urandom_range(0, 15)) : -1,
                          (i % 5 == 0) ? int'($urandom_range(1, 3)) : 0,
                          int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
